// File: rtl/eq_pkg.sv
// Shared constants and types for the equalizer output stage.
//
// DATA_W  : band sample / audio output width (signed)
// GAIN_W  : per-band gain width (unsigned)
// N_BANDS : number of equalizer bands, sequenced 0..N_BANDS-1
// SHIFT   : LSB of the output slice taken from the accumulator
// ACC_W   : accumulator width, wide enough for N_BANDS full-scale products
// PROD_W  : signed band x zero-extended gain product width
// IDX_W   : band index counter width
package eq_pkg;

  localparam int DATA_W  = 24;
  localparam int GAIN_W  = 13;
  localparam int N_BANDS = 10;
  localparam int SHIFT   = 16;
  localparam int ACC_W   = DATA_W + GAIN_W + 4;
  localparam int PROD_W  = DATA_W + GAIN_W + 1;
  localparam int IDX_W   = $clog2(N_BANDS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

endpackage

// File: rtl/eq_mac_scheduler_band_mac.sv
// band_mac: one step of the shared multiply-accumulate.
//
// Purely combinational. The gain is treated as unsigned by zero-extending
// it one bit before the signed multiply; the product is sign-extended to
// the accumulator width and added to the running sum.
//
// Ports:
//   band     in  DATA_W  signed band sample selected for this step
//   gain     in  GAIN_W  unsigned gain for the same band
//   acc      in  ACC_W   current accumulator value
//   next_acc out ACC_W   acc + band * gain
module band_mac
  import eq_pkg::*;
(
  input  logic signed [DATA_W-1:0] band,
  input  logic        [GAIN_W-1:0] gain,
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  next_acc
);

  logic signed [GAIN_W:0]   gain_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign gain_s   = $signed({1'b0, gain});
  assign prod     = band * gain_s;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign next_acc = acc + prod_ext;

endmodule

// File: rtl/eq_mac_scheduler.sv
// eq_mac_scheduler: time-multiplexed weighted sum of the equalizer bands.
//
// One shared multiplier walks the bands 0..N_BANDS-1, one per cycle, after
// a sample strobe is accepted. The result is the same bit slice of the same
// sum that a parallel multiplier / adder-tree would produce.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a sample strobe; ready is high
//   MAC   | accumulating band idx; ready only high on the final band
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_valid in   one-cycle strobe; bands_in / gains_in valid
//   bands_in     in   N_BANDS signed samples, band i at [i*DATA_W +: DATA_W]
//   gains_in     in   N_BANDS unsigned gains, gain i at [i*GAIN_W +: GAIN_W]
//   overrun_clr  in   clears the overrun flag
//   ready        out  a strobe this cycle will be accepted (decoded)
//   audio_out    out  equalized sample, held until the next result
//   out_valid    out  one-cycle pulse when audio_out is updated
//   overrun      out  sticky flag: a strobe arrived while not ready
module eq_mac_scheduler
  import eq_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_valid,
  input  logic [N_BANDS*DATA_W-1:0]   bands_in,
  input  logic [N_BANDS*GAIN_W-1:0]   gains_in,
  input  logic                        overrun_clr,
  output logic                        ready,
  output logic [DATA_W-1:0]           audio_out,
  output logic                        out_valid,
  output logic                        overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BANDS - 1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  next_acc;

  logic signed [DATA_W-1:0] band_q [N_BANDS];
  logic        [GAIN_W-1:0] gain_q [N_BANDS];

  logic signed [DATA_W-1:0] band_sel;
  logic        [GAIN_W-1:0] gain_sel;

  logic last;
  logic accept;
  logic drop;

  assign last   = (idx == LAST_IDX);
  assign ready  = (state == IDLE) | ((state == MAC) & last);
  assign accept = sample_valid & ready;
  assign drop   = sample_valid & ~ready;

  // Explicit compare mux keeps the selection in range for idx values the
  // counter never reaches.
  always_comb begin
    band_sel = '0;
    gain_sel = '0;
    for (int i = 0; i < N_BANDS; i++) begin
      if (idx == IDX_W'(i)) begin
        band_sel = band_q[i];
        gain_sel = gain_q[i];
      end
    end
  end

  band_mac u_band_mac (
    .band     (band_sel),
    .gain     (gain_sel),
    .acc      (acc),
    .next_acc (next_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= MAC;
            idx   <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          if (last) begin
            idx <= '0;
            if (accept) begin
              // back-to-back sample: restart without passing through IDLE
              acc <= '0;
            end else begin
              state <= IDLE;
              acc   <= next_acc;
            end
          end else begin
            acc <= next_acc;
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
          acc   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BANDS; i++) begin
        band_q[i] <= '0;
        gain_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N_BANDS; i++) begin
        band_q[i] <= bands_in[i*DATA_W +: DATA_W];
        gain_q[i] <= gains_in[i*GAIN_W +: GAIN_W];
      end
    end
  end

  // The top accumulator bit lies above the output slice, so wrap-around
  // behaves exactly like the combinational weighted sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == MAC) & last;
      if ((state == MAC) & last) begin
        audio_out <= next_acc[SHIFT+DATA_W-1:SHIFT];
      end
    end
  end

  // A new drop takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: doc/eq_mac_scheduler.md
# eq_mac_scheduler

Time-multiplexed multiply-accumulate scheduler for the 10-band equalizer output stage. It replaces the ten parallel band×gain multipliers and the wide adder tree with a single shared multiplier, sequenced over the bands once per audio sample. It sits between the FIR filter bank / gain register map and the audio output. Its result is bit-exact with the combinational weighted-sum path.

## Interface
- DATA_W, 24, band sample and output width (signed)
- GAIN_W, 13, per-band gain width (unsigned)
- N_BANDS, 10, number of bands, sequenced in order 0 to N_BANDS-1
- SHIFT, 16, output slice LSB: audio_out = acc[SHIFT+DATA_W-1:SHIFT]
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sample_valid  in  1  one-cycle strobe; bands_in/gains_in valid this cycle
- bands_in  in  N_BANDS*DATA_W  signed band samples; band i at [i*DATA_W +: DATA_W]
- gains_in  in  N_BANDS*GAIN_W  unsigned gains; gain i at [i*GAIN_W +: GAIN_W]
- overrun_clr  in  1  clears the overrun flag
- ready  out  1  a strobe this cycle will be accepted
- audio_out  out  DATA_W  equalized sample, held until the next result
- out_valid  out  1  one-cycle pulse; audio_out updated
- overrun  out  1  sticky; a strobe was dropped

## Operation
- **States:** IDLE, MAC. Band index idx counts 0..N_BANDS-1.
- **Accumulator:** acc, signed, DATA_W+GAIN_W+4 = 41 bits.
- **Shadow registers:** bands and gains are captured on acceptance. Inputs may change freely afterwards.
- **IDLE to MAC:** on sample_valid: capture the shadow registers, acc←0, idx←0.
- **MAC, each cycle:** acc ← acc + band[idx] × $signed({1'b0, gain[idx]}). Product is 24×14 signed, sign-extended to 41 bits. Then idx←idx+1.
- **MAC, idx == N_BANDS-1:**
  - audio_out ← next_acc[SHIFT+DATA_W-1:SHIFT].
  - out_valid←1.
  - If sample_valid is high this cycle, capture the new sample and restart at idx 0 (remain in MAC). Otherwise go to IDLE.
- **Truncation:** no rounding and no saturation. Bit 40 is discarded, so wrap-around matches the combinational path.
- **ready:** ready = (state==IDLE) | (state==MAC & idx==N_BANDS-1).
- **Dropped strobes:** sample_valid while ready=0 is dropped and sets overrun. The in-flight computation is unaffected.
- **overrun:**
  - Cleared by overrun_clr.
  - Set and clear in the same cycle: set wins.
- **Reset (any time, including mid-MAC):**
  - state=IDLE, idx=0, acc=0, shadows=0.
  - audio_out=0, out_valid=0, overrun=0.
  - ready=1 once released.
  - The in-flight sample is discarded and no out_valid is produced for it.

## Timing
- Strobe accepted at edge T: products for bands 0..9 are accumulated at edges T+1..T+10.
- out_valid is high for exactly the one cycle following edge T+10. Latency is N_BANDS cycles.
- Maximum throughput: one sample per N_BANDS cycles. The back-to-back strobe is presented in the same cycle that ready is high in MAC.
- All outputs are registered except ready, which is decoded from state and idx.
- The multiplier and adder form a single-cycle path. No pipeline stage inside the MAC.

## Structure
- **Package eq_pkg:**
  - Constants DATA_W, GAIN_W, N_BANDS, SHIFT, and ACC_W = DATA_W+GAIN_W+4.
  - State enum {IDLE, MAC}.
  - The equalizer and the register map import it.
- **Sub-module band_mac:**
  - Combinational signed×unsigned multiply plus 41-bit add.
  - Inputs: band, gain, acc. Output: next_acc.
  - The FSM, index counter, shadow registers and flags live in eq_mac_scheduler.

## Test plan
- **All bands sum:** all bands 0x010000, all gains 4096, single strobe -> out_valid 10 cycles later, audio_out=0x00A000, overrun=0.
- **Single negative band:** band3=0x800000, gain3=8191, other gains 0 -> audio_out=0xF00080.
- **Wrap-around:** all bands 0x7FFFFF, all gains 8191 -> audio_out=0x9FFAFE (truncation wrap, matches the combinational reference model).
- **Back-to-back and overrun:**
  - Strobes at T and T+10 -> out_valid at T+10 and T+20, overrun stays 0.
  - An extra strobe at T+5 is dropped, overrun=1, and the T+10 result is unchanged.
- **Reset mid-operation:** assert rst_n low at T+4 -> outputs 0 immediately, no out_valid. The next strobe after release yields a correct result 10 cycles later.
- **Overrun set/clear collision:** overrun_clr in the same cycle as a dropped strobe -> overrun remains 1. A later overrun_clr alone -> 0.
